// File: rtl/rvga_ddr_arbiter_pkg.sv
// Shared types and sizing for the l1 cache -> DDR arbiter.
package rvga_ddr_arbiter_pkg;

    localparam int LINE_BITS        = 256;
    localparam int ADDR_BITS        = 32;
    localparam int LINE_OFFSET_BITS = $clog2(LINE_BITS / 8);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } arb_client_e;

endpackage

// File: rtl/rvga_ddr_arbiter.sv
// Two-client (icache/dcache) to single DDR port arbiter.
// One transaction at a time, round-robin on ties, fully registered outputs.
module rvga_ddr_arbiter
    import rvga_ddr_arbiter_pkg::*;
#(
    parameter int line_bits = LINE_BITS,
    parameter int addr_bits = ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addr_bits-1:0] icache_arb_addr,
    input  logic                 icache_arb_read,
    output logic [line_bits-1:0] arb_icache_rdata,
    output logic                 arb_icache_resp,
    input  logic [addr_bits-1:0] dcache_arb_addr,
    input  logic                 dcache_arb_read,
    input  logic                 dcache_arb_write,
    input  logic [line_bits-1:0] dcache_arb_wdata,
    output logic [line_bits-1:0] arb_dcache_rdata,
    output logic                 arb_dcache_resp,
    output logic [addr_bits-1:0] arb_ddr_addr,
    output logic                 arb_ddr_read,
    output logic                 arb_ddr_write,
    output logic [line_bits-1:0] arb_ddr_wdata,
    input  logic [line_bits-1:0] ddr_arb_rdata,
    input  logic                 ddr_arb_resp
);

    localparam int off_bits = $clog2(line_bits / 8);

    arb_state_e  state, state_n;
    arb_client_e last_grant;
    logic        i_req, d_req;

    assign i_req = icache_arb_read;
    assign d_req = dcache_arb_read | dcache_arb_write;

    // Byte-offset bits inside a line are never sent to DDR.
    logic unused_offset;
    assign unused_offset = ^{icache_arb_addr[off_bits-1:0], dcache_arb_addr[off_bits-1:0]};

    function automatic logic [addr_bits-1:0] line_addr(input logic [addr_bits-1:0] a);
        return {a[addr_bits-1:off_bits], {off_bits{1'b0}}};
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state: ties go to whoever was not served last.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (i_req && d_req)
                    state_n = (last_grant == ICACHE) ? GRANT_D : GRANT_I;
                else if (d_req)
                    state_n = GRANT_D;
                else if (i_req)
                    state_n = GRANT_I;
            end
            GRANT_I, GRANT_D: if (ddr_arb_resp) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Grant datapath: capture request on grant, return data on DDR completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_ddr_addr     <= '0;
            arb_ddr_read     <= 1'b0;
            arb_ddr_write    <= 1'b0;
            arb_ddr_wdata    <= '0;
            arb_icache_rdata <= '0;
            arb_dcache_rdata <= '0;
            arb_icache_resp  <= 1'b0;
            arb_dcache_resp  <= 1'b0;
            last_grant       <= ICACHE;
        end else begin
            arb_icache_resp <= 1'b0;
            arb_dcache_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_n == GRANT_I) begin
                        arb_ddr_addr  <= line_addr(icache_arb_addr);
                        arb_ddr_read  <= 1'b1;
                        arb_ddr_write <= 1'b0;
                        arb_ddr_wdata <= '0;
                    end else if (state_n == GRANT_D) begin
                        // read+write together is illegal; the write takes precedence
                        arb_ddr_addr  <= line_addr(dcache_arb_addr);
                        arb_ddr_read  <= ~dcache_arb_write;
                        arb_ddr_write <= dcache_arb_write;
                        arb_ddr_wdata <= dcache_arb_write ? dcache_arb_wdata : '0;
                    end
                end
                GRANT_I: begin
                    if (ddr_arb_resp) begin
                        arb_ddr_read     <= 1'b0;
                        arb_ddr_write    <= 1'b0;
                        arb_icache_rdata <= ddr_arb_rdata;
                        arb_icache_resp  <= 1'b1;
                        last_grant       <= ICACHE;
                    end
                end
                GRANT_D: begin
                    if (ddr_arb_resp) begin
                        if (arb_ddr_read) arb_dcache_rdata <= ddr_arb_rdata;
                        arb_ddr_read    <= 1'b0;
                        arb_ddr_write   <= 1'b0;
                        arb_dcache_resp <= 1'b1;
                        last_grant      <= DCACHE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(dcache_arb_read && dcache_arb_write));
    a_ddr_resp_in_grant: assert property (@(posedge clk) disable iff (rst)
        ddr_arb_resp |-> (state == GRANT_I || state == GRANT_D));
    a_single_resp: assert property (@(posedge clk) disable iff (rst)
        !(arb_icache_resp && arb_dcache_resp));
`endif

endmodule

// File: tb/tb_rvga_ddr_arbiter.sv
// Self-checking bench: transaction-level reference model plus directed scenarios
// and a randomized two-client traffic phase.
module tb_rvga_ddr_arbiter;

    logic         clk, rst;
    logic [31:0]  icache_arb_addr, dcache_arb_addr, arb_ddr_addr;
    logic         icache_arb_read, dcache_arb_read, dcache_arb_write;
    logic [255:0] arb_icache_rdata, arb_dcache_rdata, dcache_arb_wdata;
    logic [255:0] arb_ddr_wdata, ddr_arb_rdata;
    logic         arb_icache_resp, arb_dcache_resp, arb_ddr_read, arb_ddr_write;
    logic         ddr_arb_resp;

    int checks = 0;
    int errors = 0;

    rvga_ddr_arbiter dut (
        .clk(clk), .rst(rst),
        .icache_arb_addr(icache_arb_addr), .icache_arb_read(icache_arb_read),
        .arb_icache_rdata(arb_icache_rdata), .arb_icache_resp(arb_icache_resp),
        .dcache_arb_addr(dcache_arb_addr), .dcache_arb_read(dcache_arb_read),
        .dcache_arb_write(dcache_arb_write), .dcache_arb_wdata(dcache_arb_wdata),
        .arb_dcache_rdata(arb_dcache_rdata), .arb_dcache_resp(arb_dcache_resp),
        .arb_ddr_addr(arb_ddr_addr), .arb_ddr_read(arb_ddr_read),
        .arb_ddr_write(arb_ddr_write), .arb_ddr_wdata(arb_ddr_wdata),
        .ddr_arb_rdata(ddr_arb_rdata), .ddr_arb_resp(ddr_arb_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- DDR responder: completes after lat cycles of strobe ----
    int           lat_fixed = 3;
    int           ddr_cnt, ddr_lat;
    logic [255:0] ddr_last_line;

    initial begin
        ddr_arb_resp  = 1'b0;
        ddr_arb_rdata = '0;
        ddr_cnt       = 0;
        ddr_lat       = 1;
        ddr_last_line = '0;
        forever begin
            @(negedge clk);
            if (rst || !(arb_ddr_read || arb_ddr_write)) begin
                ddr_arb_resp = 1'b0;
                ddr_cnt      = 0;
            end else begin
                if (ddr_cnt == 0) ddr_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
                ddr_cnt++;
                if (ddr_cnt == ddr_lat) begin
                    ddr_arb_rdata = {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
                    ddr_last_line = ddr_arb_rdata;
                    ddr_arb_resp  = 1'b1;
                end else begin
                    ddr_arb_resp = 1'b0;
                end
            end
        end
    end

    // ---------------- Reference model ---------------------------------------
    // owner: -1 none, 0 icache, 1 dcache. After a completion there is one
    // response cycle and one dead cycle before requests are looked at again.
    int           m_owner, m_last, m_gap;
    logic         e_rd, e_wr, e_iresp, e_dresp;
    logic [31:0]  e_addr;
    logic [255:0] e_wdata, e_irdata, e_drdata;

    function automatic int pick(input logic ireq, input logic dreq, input int last);
        if (ireq && dreq) return (last == 0) ? 1 : 0;
        if (dreq) return 1;
        if (ireq) return 0;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1; m_last <= 0; m_gap <= 0;
            e_rd <= 0; e_wr <= 0; e_iresp <= 0; e_dresp <= 0;
            e_addr <= '0; e_wdata <= '0; e_irdata <= '0; e_drdata <= '0;
        end else begin
            e_iresp <= 0;
            e_dresp <= 0;
            if (m_owner >= 0) begin
                if (ddr_arb_resp) begin
                    if (m_owner == 0) begin
                        e_irdata <= ddr_arb_rdata; e_iresp <= 1;
                    end else begin
                        if (!e_wr) e_drdata <= ddr_arb_rdata;
                        e_dresp <= 1;
                    end
                    m_last <= m_owner; m_owner <= -1; m_gap <= 2;
                    e_rd <= 0; e_wr <= 0;
                end
            end else if (m_gap > 1) begin
                m_gap <= m_gap - 1;
            end else begin
                m_gap <= 0;
                case (pick(icache_arb_read, dcache_arb_read | dcache_arb_write, m_last))
                    0: begin
                        m_owner <= 0; e_rd <= 1; e_wr <= 0;
                        e_addr  <= (icache_arb_addr >> 5) << 5;
                    end
                    1: begin
                        m_owner <= 1; e_rd <= !dcache_arb_write; e_wr <= dcache_arb_write;
                        e_addr  <= (dcache_arb_addr >> 5) << 5;
                        e_wdata <= dcache_arb_wdata;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        chk("ddr_read", arb_ddr_read, e_rd);
        chk("ddr_write", arb_ddr_write, e_wr);
        if (e_rd || e_wr) chk("ddr_addr", arb_ddr_addr, e_addr);
        if (e_wr) chk("ddr_wdata", arb_ddr_wdata, e_wdata);
        chk("icache_resp", arb_icache_resp, e_iresp);
        chk("dcache_resp", arb_dcache_resp, e_dresp);
        chk("icache_rdata", arb_icache_rdata, e_irdata);
        chk("dcache_rdata", arb_dcache_rdata, e_drdata);
    end

    // ---------------- Directed + random stimulus ----------------------------
    task automatic clear_inputs();
        icache_arb_read = 0; icache_arb_addr = '0;
        dcache_arb_read = 0; dcache_arb_write = 0;
        dcache_arb_addr = '0; dcache_arb_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    int           nrd, nwr, seen, when, n, overlap, extra, rd_seen, ni, nd;
    int           order [8];
    logic [31:0]  addr_seen;
    logic [255:0] line, wd, line_exp;

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk("t0_strobes", {arb_ddr_read, arb_ddr_write, arb_icache_resp, arb_dcache_resp}, 0);
        chk("t0_addr", arb_ddr_addr, 0);
        chk("t0_wdata", arb_ddr_wdata, 0);
        chk("t0_irdata", arb_icache_rdata, 0);
        chk("t0_drdata", arb_dcache_rdata, 0);
        rst = 1'b0;

        // 1: lone icache read, latency 3
        lat_fixed = 3;
        @(negedge clk);
        icache_arb_addr = 32'h0000_1044; icache_arb_read = 1;
        nrd = 0; seen = 0; when = 0; addr_seen = '0; line = '0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            if (arb_ddr_read) begin nrd++; addr_seen = arb_ddr_addr; end
            if (arb_icache_resp) begin seen = 1; when = k; line = arb_icache_rdata; icache_arb_read = 0; end
        end
        extra = 0;
        repeat (4) begin @(negedge clk); if (arb_icache_resp) extra++; end
        chk("t1_resp_seen", seen, 1);
        chk("t1_addr", addr_seen, 32'h0000_1040);
        chk("t1_read_cycles", nrd, 3);
        chk("t1_resp_cycle", when, 4);
        chk("t1_line", line, ddr_last_line);
        chk("t1_single_pulse", extra, 0);

        // 2: simultaneous after reset -> dcache first
        do_reset();
        lat_fixed = 2;
        icache_arb_addr = 32'h0000_0100; icache_arb_read = 1;
        dcache_arb_addr = 32'h0000_0200; dcache_arb_read = 1;
        n = 0; overlap = 0;
        for (int k = 0; k < 40 && n < 2; k++) begin
            @(negedge clk);
            if (arb_icache_resp && arb_dcache_resp) overlap++;
            if (arb_dcache_resp) begin order[n] = 1; n++; dcache_arb_read = 0; end
            if (arb_icache_resp && n < 8) begin order[n] = 0; n++; icache_arb_read = 0; end
        end
        chk("t2_count", n, 2);
        chk("t2_first_dcache", order[0], 1);
        chk("t2_second_icache", order[1], 0);
        chk("t2_no_overlap", overlap, 0);

        // 3: both held for 8 transactions -> D,I,D,I...
        do_reset();
        lat_fixed = 0;
        icache_arb_addr = 32'h0000_3000; icache_arb_read = 1;
        dcache_arb_addr = 32'h0000_4000; dcache_arb_read = 1;
        n = 0;
        for (int k = 0; k < 300 && n < 8; k++) begin
            @(negedge clk);
            if (arb_dcache_resp && n < 8) begin order[n] = 1; n++; end
            if (arb_icache_resp && n < 8) begin order[n] = 0; n++; end
        end
        icache_arb_read = 0; dcache_arb_read = 0;
        chk("t3_count", n, 8);
        for (int k = 0; k < 8; k++) chk($sformatf("t3_grant%0d", k), order[k], (k % 2 == 0) ? 1 : 0);

        // 4: dcache write leaves dcache rdata untouched
        do_reset();
        lat_fixed = 2;
        dcache_arb_addr = 32'h0000_3000; dcache_arb_read = 1;
        seen = 0; line_exp = '0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (arb_dcache_resp) begin seen = 1; line_exp = ddr_last_line; dcache_arb_read = 0; end
        end
        repeat (2) @(negedge clk);
        dcache_arb_addr = 32'h0000_2000; dcache_arb_wdata = {32{8'hA5}}; dcache_arb_write = 1;
        nwr = 0; rd_seen = 0; seen = 0; addr_seen = '0; wd = '0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (arb_ddr_write) begin nwr++; addr_seen = arb_ddr_addr; wd = arb_ddr_wdata; end
            if (arb_ddr_read) rd_seen++;
            if (arb_dcache_resp) begin seen = 1; dcache_arb_write = 0; end
        end
        chk("t4_resp_seen", seen, 1);
        chk("t4_write_cycles", nwr, 2);
        chk("t4_no_read", rd_seen, 0);
        chk("t4_addr", addr_seen, 32'h0000_2000);
        chk("t4_wdata", wd, {32{8'hA5}});
        chk("t4_rdata_kept", arb_dcache_rdata, line_exp);

        // 5: async reset during a dcache grant
        do_reset();
        lat_fixed = 4;
        dcache_arb_addr = 32'h0000_4000; dcache_arb_read = 1;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (arb_ddr_read) seen = 1;
        end
        chk("t5_granted", seen, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_strobes", {arb_ddr_read, arb_ddr_write, arb_icache_resp, arb_dcache_resp}, 0);
        chk("t5_rst_addr", arb_ddr_addr, 0);
        chk("t5_rst_rdata", {arb_icache_rdata, arb_dcache_rdata} == 0, 1);
        dcache_arb_read = 0;
        @(negedge clk);
        rst = 1'b0;
        lat_fixed = 2;
        icache_arb_addr = 32'h0000_5008; icache_arb_read = 1;
        seen = 0; addr_seen = '0;
        for (int k = 0; k < 20 && seen == 0; k++) begin
            @(negedge clk);
            if (arb_ddr_read) addr_seen = arb_ddr_addr;
            if (arb_icache_resp) begin seen = 1; icache_arb_read = 0; end
        end
        chk("t5_after_resp", seen, 1);
        chk("t5_after_addr", addr_seen, 32'h0000_5000);

        // 6: icache drops mid-grant, still gets exactly one pulse, no regrant
        do_reset();
        lat_fixed = 3;
        icache_arb_addr = 32'h0000_6000; icache_arb_read = 1;
        for (int k = 0; k < 10 && icache_arb_read; k++) begin
            @(negedge clk);
            if (arb_ddr_read) icache_arb_read = 0;
        end
        n = 0; extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (n > 0 && (arb_ddr_read || arb_ddr_write)) extra++;
            if (arb_icache_resp) n++;
        end
        chk("t6_pulses", n, 1);
        chk("t6_no_regrant", extra, 0);

        // Random traffic from both clients, checked cycle by cycle by the model.
        do_reset();
        lat_fixed = 0;
        ni = 0; nd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (arb_icache_resp) ni++;
            if (arb_dcache_resp) nd++;
            if (icache_arb_read) begin
                if (arb_icache_resp || $urandom_range(0, 49) == 0) icache_arb_read = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                icache_arb_addr = $urandom; icache_arb_read = 1;
            end
            if (dcache_arb_read || dcache_arb_write) begin
                if (arb_dcache_resp || $urandom_range(0, 49) == 0) begin
                    dcache_arb_read = 0; dcache_arb_write = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                dcache_arb_addr  = $urandom;
                dcache_arb_wdata = {$urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom};
                if ($urandom_range(0, 1) == 0) dcache_arb_read = 1;
                else dcache_arb_write = 1;
            end
        end
        chk("rand_icache_served", ni > 20, 1);
        chk("rand_dcache_served", nd > 20, 1);

        clear_inputs();
        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
